muldiv_seq: RTL

Parametrised multi-cycle multiply/divide unit that feeds the Hi and Lo registers of the multi-cycle CPU datapath. It replaces the fixed 32-bit multiply/divide slot with a WIDTH-generic engine that has four modes and a start/busy/done handshake. It also reports division by zero to the exception-control path. Operands come from the A and B registers; results are loaded into Hi/Lo by the control unit's HiWrite/LoWrite when `done` pulses.

---
 rtl/muldiv_pkg.sv | 14 +
 rtl/muldiv_if.sv | 14 +
 rtl/muldiv_sign_fix.sv | 8 +
 rtl/muldiv_seq.sv | 98 +++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and op-decode helpers shared by the multiply/divide unit
package muldiv_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction
  function automatic logic is_signed_op(input logic [1:0] op);
    return !op[0];
  endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done request bus between control unit (master) and muldiv_seq (slave)
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, a, b, input busy, done, div_zero, hi, lo);
  modport slave(input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate for operand magnitudes and result signs
module muldiv_sign_fix #(parameter int W = 32) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);
  assign val_o = neg_i ? -val_i : val_i;
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle signed/unsigned multiply and divide; MULDIV_EARLY_OUT_EN enables multiply early exit
module muldiv_seq import muldiv_pkg::*; #(parameter int WIDTH = 32) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t             state_q;
  logic [1:0]         op_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, x_q, acc_d, x_d, prod_fix;
  logic [WIDTH-1:0]   y_q, y_d, hi_q, lo_q, a_mag, b_mag, quo_fix, rem_fix;
  logic [WIDTH:0]     trial;
  logic               neg_q, rneg_q, busy_q, done_q, dz_q, sa, sb, ge, last, early;
  assign sa = is_signed_op(bus.op) & bus.a[WIDTH-1];
  assign sb = is_signed_op(bus.op) & bus.b[WIDTH-1];
  muldiv_sign_fix #(.W(WIDTH))   u_amag (.neg_i(sa),     .val_i(bus.a),            .val_o(a_mag));
  muldiv_sign_fix #(.W(WIDTH))   u_bmag (.neg_i(sb),     .val_i(bus.b),            .val_o(b_mag));
  muldiv_sign_fix #(.W(2*WIDTH)) u_prod (.neg_i(neg_q),  .val_i(acc_q),            .val_o(prod_fix));
  muldiv_sign_fix #(.W(WIDTH))   u_quo  (.neg_i(neg_q),  .val_i(y_q),              .val_o(quo_fix));
  muldiv_sign_fix #(.W(WIDTH))   u_rem  (.neg_i(rneg_q), .val_i(acc_q[WIDTH-1:0]), .val_o(rem_fix));
  // One CALC step: multiply adds the shifted multiplicand per multiplier LSB; divide does one restoring subtract
  always_comb begin
    trial = {acc_q[WIDTH-1:0], y_q[WIDTH-1]};
    ge    = trial >= {1'b0, x_q[WIDTH-1:0]};
    acc_d = is_div_op(op_q) ? {{WIDTH{1'b0}}, ge ? WIDTH'(trial - {1'b0, x_q[WIDTH-1:0]}) : trial[WIDTH-1:0]}
                            : acc_q + (y_q[0] ? x_q : '0);
    x_d   = is_div_op(op_q) ? x_q : x_q << 1;
    y_d   = is_div_op(op_q) ? {y_q[WIDTH-2:0], ge} : y_q >> 1;
  end
  assign last = cnt_q == CW'(WIDTH - 1);
`ifdef MULDIV_EARLY_OUT_EN
  assign early = !is_div_op(op_q) && y_d == '0;
`else
  assign early = 1'b0;
`endif
  // Control FSM; start is taken in DONE as in IDLE so operations can run back to back
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          dz_q    <= 1'b0;
          if (bus.start) begin
            op_q   <= bus.op;
            cnt_q  <= '0;
            acc_q  <= '0;
            x_q    <= {{WIDTH{1'b0}}, is_div_op(bus.op) ? b_mag : a_mag};
            y_q    <= is_div_op(bus.op) ? a_mag : b_mag;
            neg_q  <= sa ^ sb;
            rneg_q <= sa;
            if (is_div_op(bus.op) && bus.b == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              dz_q    <= 1'b1;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          x_q   <= x_d;
          y_q   <= y_d;
          cnt_q <= cnt_q + CW'(1);
          if (last || early) state_q <= S_FIX;
        end
        S_FIX: begin
          state_q      <= S_DONE;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          {hi_q, lo_q} <= is_div_op(op_q) ? {rem_fix, quo_fix} : prod_fix;
        end
      endcase
    end
  end
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule
